// File: rtl/bmp_stream_writer_if.sv
// Handshake bundle for bmp_stream_writer: frame control, pixel input stream
// and serialised byte output stream.
interface bmp_stream_writer_if;
    logic        start;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, pix_data, pix_valid, byte_ready,
        input  pix_ready, byte_out, byte_valid, busy, done
    );

    modport slave (
        input  start, pix_data, pix_valid, byte_ready,
        output pix_ready, byte_out, byte_valid, busy, done
    );
endinterface

// File: rtl/bmp_stream_writer.sv
// Serialises a 24-bpp top-down BMP file (54-byte header, B/G/R pixel bytes,
// rows padded to 4 bytes) from a pixel stream onto a ready/valid byte stream.
module bmp_stream_writer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned XPPM   = 2835
) (
    input  logic                i_clk,
    input  logic                i_reset,
    bmp_stream_writer_if.slave  bus
);
    localparam int unsigned ROWBYTES = ((3 * WIDTH + 3) / 4) * 4;
    localparam int unsigned PAD      = ROWBYTES - 3 * WIDTH;
    localparam int unsigned IMGSIZE  = ROWBYTES * HEIGHT;
    localparam int unsigned FSIZE    = 54 + IMGSIZE;

    localparam logic [11:0] LAST_COL = 12'(WIDTH - 1);
    localparam logic [11:0] LAST_ROW = 12'(HEIGHT - 1);
    localparam logic [1:0]  PAD_LAST = 2'(PAD + 3);
    localparam logic [31:0] NEGH32   = 32'(32'd0 - 32'(HEIGHT));

    // Header packed so that file byte k sits at bits [8k+7:8k]; every
    // multi-byte field is therefore little-endian for free.
    localparam logic [431:0] HDR = {
        64'd0, 32'(XPPM), 32'(XPPM), 32'(IMGSIZE), 32'd0,
        16'd24, 16'd1, NEGH32, 32'(WIDTH), 32'd40, 32'd54, 32'd0,
        32'(FSIZE), 8'h4D, 8'h42
    };

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_PIXEL, S_PAD, S_FLUSH
    } state_t;

    state_t      r_state;
    logic [5:0]  r_hdr_idx;
    logic [11:0] r_col;
    logic [11:0] r_row;
    logic [1:0]  r_sub;
    logic [1:0]  r_pad;
    logic [15:0] r_gr;
    logic [7:0]  r_byte_out;
    logic        r_byte_valid;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_hdr [0:53];
    logic        w_slot_free;
    logic        w_pix_ready;
    logic        w_pix_take;

    for (genvar gi = 0; gi < 54; gi++) begin : g_hdr
        assign w_hdr[gi] = HDR[gi * 8 +: 8];
    end

    assign w_slot_free = !r_byte_valid || bus.byte_ready;
    assign w_pix_ready = (r_state == S_PIXEL) && w_slot_free && (r_sub == 2'd0);
    assign w_pix_take  = w_pix_ready && bus.pix_valid;

    assign bus.pix_ready  = w_pix_ready;
    assign bus.byte_out   = r_byte_out;
    assign bus.byte_valid = r_byte_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_hdr_idx    <= 6'd0;
            r_col        <= 12'd0;
            r_row        <= 12'd0;
            r_sub        <= 2'd0;
            r_pad        <= 2'd0;
            r_gr         <= 16'd0;
            r_byte_out   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A consumed byte retires unless a new one is loaded below.
            if (w_slot_free) begin
                r_byte_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !r_done) begin
                        r_state   <= S_HEADER;
                        r_busy    <= 1'b1;
                        r_hdr_idx <= 6'd0;
                    end
                end
                S_HEADER: begin
                    if (w_slot_free) begin
                        r_byte_out   <= w_hdr[r_hdr_idx];
                        r_byte_valid <= 1'b1;
                        if (r_hdr_idx == 6'd53) begin
                            r_state <= S_PIXEL;
                            r_col   <= 12'd0;
                            r_row   <= 12'd0;
                            r_sub   <= 2'd0;
                        end else begin
                            r_hdr_idx <= r_hdr_idx + 6'd1;
                        end
                    end
                end
                S_PIXEL: begin
                    if (w_pix_take) begin
                        r_byte_out   <= bus.pix_data[7:0];
                        r_byte_valid <= 1'b1;
                        r_gr         <= bus.pix_data[23:8];
                        r_sub        <= 2'd1;
                    end else if (w_slot_free && r_sub == 2'd1) begin
                        r_byte_out   <= r_gr[7:0];
                        r_byte_valid <= 1'b1;
                        r_sub        <= 2'd2;
                    end else if (w_slot_free && r_sub == 2'd2) begin
                        r_byte_out   <= r_gr[15:8];
                        r_byte_valid <= 1'b1;
                        r_sub        <= 2'd0;
                        if (r_col != LAST_COL) begin
                            r_col <= r_col + 12'd1;
                        end else if (PAD != 0) begin
                            r_state <= S_PAD;
                            r_pad   <= 2'd0;
                        end else begin
                            r_col   <= 12'd0;
                            r_row   <= r_row + 12'd1;
                            r_state <= (r_row == LAST_ROW) ? S_FLUSH : S_PIXEL;
                        end
                    end
                end
                S_PAD: begin
                    if (w_slot_free) begin
                        r_byte_out   <= 8'd0;
                        r_byte_valid <= 1'b1;
                        if (r_pad == PAD_LAST) begin
                            r_col   <= 12'd0;
                            r_row   <= r_row + 12'd1;
                            r_state <= (r_row == LAST_ROW) ? S_FLUSH : S_PIXEL;
                        end else begin
                            r_pad <= r_pad + 2'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    // The final byte is always pending here; finish on its handshake.
                    if (w_slot_free) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
